// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard stall unit: FSM state encoding,
// source-register field positions and the front-end control bundles.
package hazard_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int REG_W   = 5;
  localparam int RS1_LSB = 0;
  localparam int RS2_LSB = 5;

  // Front-end pipeline-register controls driven by this block.
  typedef struct packed {
    logic pc_hold;
    logic if_id_hold;
    logic id_ex_hold;
    logic id_ex_flush;
    logic ex_m_bubble;
  } hold_ctrl_t;

  // No hold, no flush, no bubble: the pipeline advances normally.
  localparam hold_ctrl_t CTRL_NOP = '0;

  // Multiply in EX: freeze the front end and feed NOPs into EX/MEM.
  localparam hold_ctrl_t CTRL_MULT = '{pc_hold: 1'b1, if_id_hold: 1'b1,
                                       id_ex_hold: 1'b1, id_ex_flush: 1'b0,
                                       ex_m_bubble: 1'b1};

  // Load-use: freeze PC and IF/ID, turn ID/EX into a NOP for one cycle.
  localparam hold_ctrl_t CTRL_LOAD_USE = '{pc_hold: 1'b1, if_id_hold: 1'b1,
                                           id_ex_hold: 1'b0, id_ex_flush: 1'b1,
                                           ex_m_bubble: 1'b0};

  // A load destination only matters if it is a real register (not x0).
  function automatic logic reg_dep(input logic [REG_W-1:0] rd,
                                   input logic [REG_W-1:0] rs);
    return (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating up-counter with enable; sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_arst,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Count enabled cycles, holding once every bit is set.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst)
      r_count <= '0;
    else if (i_en && (r_count != {W{1'b1}}))
      r_count <= r_count + W'(1);
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/bubble controller beside ID. Freezes the front end while a
// multi-cycle multiply occupies EX and inserts a one-cycle bubble on a
// load-use dependency. Hold outputs are Mealy (same-cycle) responses.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = 3,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic [9:0]             if_id_rs1_2,
  input  logic [4:0]             id_ex_rd,
  input  logic                   id_ex_mem_read,
  input  logic                   id_ex_is_mult,
  output logic                   pc_hold,
  output logic                   if_id_hold,
  output logic                   id_ex_hold,
  output logic                   id_ex_flush,
  output logic                   ex_m_bubble,
  output logic                   mult_busy,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam int                CNT_W       = $clog2(MULT_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(MULT_CYCLES - 1);
  // A single-cycle multiply finishes in EX like any ALU op.
  localparam logic              MULT_STALLS = (MULT_CYCLES > 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic [REG_W-1:0] w_rs1;
  logic [REG_W-1:0] w_rs2;
  logic             w_load_use;
  hold_ctrl_t       w_ctrl;

  assign w_rs1 = if_id_rs1_2[RS1_LSB +: REG_W];
  assign w_rs2 = if_id_rs1_2[RS2_LSB +: REG_W];

  assign w_load_use = id_ex_mem_read &&
                      (reg_dep(id_ex_rd, w_rs1) || reg_dep(id_ex_rd, w_rs2));

  // State and multiply-cycle counter; reset aborts any multiply in flight.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: IDLE starts a multiply at cnt=1; BUSY counts to the last cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (id_ex_is_mult && MULT_STALLS) begin
          w_state_nxt = BUSY;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      BUSY: begin
        if (r_cnt < CNT_LAST) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end else begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs: multiply hold beats load-use; everything drops while in reset
  // so a stale multiply in EX cannot re-hold during the reset pulse.
  always_comb begin
    w_ctrl = CTRL_NOP;
    if (!arst) begin
      case (r_state)
        IDLE: begin
          if (id_ex_is_mult) begin
            if (MULT_STALLS) w_ctrl = CTRL_MULT;
          end else if (w_load_use) begin
            w_ctrl = CTRL_LOAD_USE;
          end
        end
        BUSY: begin
          // Final cycle releases so the product latches into EX/MEM.
          if (r_cnt < CNT_LAST) w_ctrl = CTRL_MULT;
        end
        default: w_ctrl = CTRL_NOP;
      endcase
    end
  end

  assign pc_hold     = w_ctrl.pc_hold;
  assign if_id_hold  = w_ctrl.if_id_hold;
  assign id_ex_hold  = w_ctrl.id_ex_hold;
  assign id_ex_flush = w_ctrl.id_ex_flush;
  assign ex_m_bubble = w_ctrl.ex_m_bubble;
  assign mult_busy   = (r_state == BUSY);

  sat_counter #(
    .W (STALL_CNT_W)
  ) u_stall_cnt (
    .i_clk   (clk),
    .i_arst  (arst),
    .i_en    (w_ctrl.pc_hold),
    .o_count (stall_cycles)
  );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench: the driver pushes hand-computed expectations each cycle
// it wants checked; a monitor on the falling edge pops and compares.
module tb_hazard_stall_unit;

  localparam int MC = 3;
  localparam int SW = 8;

  typedef struct packed {
    logic [4:0]    h;     // {pc_hold, if_id_hold, id_ex_hold, id_ex_flush, ex_m_bubble}
    logic          busy;
    logic [SW-1:0] stall;
  } exp_t;

  localparam logic [4:0] HN = 5'b00000;
  localparam logic [4:0] HM = 5'b11101;
  localparam logic [4:0] HL = 5'b11010;

  logic          clk = 1'b0;
  logic          arst = 1'b1;
  logic [9:0]    if_id_rs1_2 = '0;
  logic [4:0]    id_ex_rd = '0;
  logic          id_ex_mem_read = 1'b0;
  logic          id_ex_is_mult = 1'b0;
  logic          pc_hold, if_id_hold, id_ex_hold, id_ex_flush, ex_m_bubble;
  logic          mult_busy;
  logic [SW-1:0] stall_cycles;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  hazard_stall_unit #(.MULT_CYCLES(MC), .STALL_CNT_W(SW)) dut (
    .clk            (clk),
    .arst           (arst),
    .if_id_rs1_2    (if_id_rs1_2),
    .id_ex_rd       (id_ex_rd),
    .id_ex_mem_read (id_ex_mem_read),
    .id_ex_is_mult  (id_ex_is_mult),
    .pc_hold        (pc_hold),
    .if_id_hold     (if_id_hold),
    .id_ex_hold     (id_ex_hold),
    .id_ex_flush    (id_ex_flush),
    .ex_m_bubble    (ex_m_bubble),
    .mult_busy      (mult_busy),
    .stall_cycles   (stall_cycles)
  );

  always #5 clk = ~clk;

  // Monitor: compare whatever the driver queued for this cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      exp_t  a;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a.h     = {pc_hold, if_id_hold, id_ex_hold, id_ex_flush, ex_m_bubble};
      a.busy  = mult_busy;
      a.stall = stall_cycles;
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got h=%b busy=%b stall=%0d, want h=%b busy=%b stall=%0d",
                 n, a.h, a.busy, a.stall, e.h, e.busy, e.stall);
      end
    end
  end

  task automatic drive(input logic m, input logic mr, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    @(posedge clk);
    #1;
    id_ex_is_mult  = m;
    id_ex_mem_read = mr;
    id_ex_rd       = rd;
    if_id_rs1_2    = {rs2, rs1};
  endtask

  task automatic expect_out(input string n, input logic [4:0] h,
                            input logic b, input int s);
    exp_t e;
    e.h = h; e.busy = b; e.stall = SW'(s);
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    arst = 1'b1;
    id_ex_is_mult = 1'b0; id_ex_mem_read = 1'b0; id_ex_rd = '0; if_id_rs1_2 = '0;
    @(posedge clk);
    #1;
    arst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    expect_out("reset_state", HN, 1'b0, 0);
    @(posedge clk); @(posedge clk);
    #1 arst = 1'b0;

    // Single multiply: two hold cycles, release on the third
    drive(1, 0, 0, 0, 0); expect_out("mul1_c0", HM, 0, 0);
    drive(1, 0, 0, 0, 0); expect_out("mul1_c1", HM, 1, 1);
    drive(1, 0, 0, 0, 0); expect_out("mul1_rel", HN, 1, 2);
    drive(0, 0, 0, 0, 0); expect_out("mul1_idle", HN, 0, 2);

    // Back-to-back multiplies
    do_reset();
    drive(1, 0, 0, 0, 0); expect_out("b2b_a0", HM, 0, 0);
    drive(1, 0, 0, 0, 0); expect_out("b2b_a1", HM, 1, 1);
    drive(1, 0, 0, 0, 0); expect_out("b2b_arel", HN, 1, 2);
    drive(1, 0, 0, 0, 0); expect_out("b2b_b0", HM, 0, 2);
    drive(1, 0, 0, 0, 0); expect_out("b2b_b1", HM, 1, 3);
    drive(1, 0, 0, 0, 0); expect_out("b2b_brel", HN, 1, 4);
    drive(0, 0, 0, 0, 0); expect_out("b2b_after0", HN, 0, 4);
    drive(0, 0, 0, 0, 0); expect_out("b2b_after1", HN, 0, 4);

    // Load-use on rs2, x0 immunity, rs1 match, non-load
    do_reset();
    drive(0, 1, 5'd5, 5'd3, 5'd5); expect_out("lu_rs2", HL, 0, 0);
    drive(0, 0, 5'd5, 5'd3, 5'd5); expect_out("lu_clear", HN, 0, 1);
    drive(0, 1, 5'd0, 5'd0, 5'd0); expect_out("lu_x0", HN, 0, 1);
    drive(0, 1, 5'd7, 5'd7, 5'd2); expect_out("lu_rs1", HL, 0, 1);
    drive(0, 0, 5'd7, 5'd7, 5'd2); expect_out("lu_noload", HN, 0, 2);
    // Multiply and load-use match together: multiply wins, no flush
    drive(1, 1, 5'd9, 5'd9, 5'd0); expect_out("prio_mul", HM, 0, 2);
    drive(1, 0, 5'd9, 5'd9, 5'd0); expect_out("prio_busy", HM, 1, 3);
    drive(1, 0, 5'd9, 5'd9, 5'd0); expect_out("prio_rel", HN, 1, 4);
    // Dependent load right after the multiply
    drive(0, 1, 5'd4, 5'd1, 5'd4); expect_out("lu_after_mul", HL, 0, 4);
    drive(0, 0, 5'd0, 5'd0, 5'd0); expect_out("lu_after_clr", HN, 0, 5);

    // Reset mid-BUSY (cnt=1) with the multiply still presented
    do_reset();
    drive(1, 0, 0, 0, 0); expect_out("rb_c0", HM, 0, 0);
    drive(1, 0, 0, 0, 0);
    #1 arst = 1'b1;
    expect_out("rb_abort", HN, 0, 0);
    @(posedge clk);
    #1;
    arst = 1'b0; id_ex_is_mult = 1'b0;
    expect_out("rb_release", HN, 0, 0);
    drive(0, 0, 0, 0, 0); expect_out("rb_quiet", HN, 0, 0);

    // Saturation: 2^SW+3 consecutive load-use stall cycles
    do_reset();
    for (int i = 0; i < (1 << SW) + 3; i++) begin
      drive(0, 1, 5'd6, 5'd6, 5'd0);
      if (i == 254) expect_out("sat_254", HL, 0, 254);
      if (i == 255) expect_out("sat_255", HL, 0, 255);
    end
    drive(0, 0, 0, 0, 0); expect_out("sat_nowrap", HN, 0, 255);

    @(posedge clk); @(posedge clk);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
